// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of one shared bit-serial full adder.
// Operands are streamed LSB-first for WIDTH cycles; the result is held until taken.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_id;
    logic             r_last_grant;
    logic [CW-1:0]    r_cnt;
    logic             w_gnt_id;
    logic             w_accept;
    logic             w_sum_bit;
    logic             w_carry_next;

    // One-bit full adder built only from XOR/AND/OR; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic p;
        p = a ^ b;
        return {(a & b) | (c & p), p ^ c};
    endfunction

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        w_gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_gnt_id = 1'b1;
        end else begin
            w_gnt_id = 1'b0;
        end
        w_accept   = (r_state == S_IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = w_accept && !w_gnt_id;
        req1_ready = w_accept && w_gnt_id;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_ADD;
                else          w_state_next = S_IDLE;
            end
            S_ADD: begin
                if (r_cnt == LAST_BIT) w_state_next = S_DONE;
                else                   w_state_next = S_ADD;
            end
            S_DONE: begin
                if (res_ready) w_state_next = S_IDLE;
                else           w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Current bit pair always sits at position 0 because the operands shift right.
    always_comb begin
        {w_carry_next, w_sum_bit} = full_add(r_a[0], r_b[0], r_carry);
    end

    // State, operand latch, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_gnt_id ? req1_a : req0_a;
                        r_b          <= w_gnt_id ? req1_b : req0_b;
                        r_id         <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_carry      <= 1'b0;
                        r_cnt        <= '0;
                    end
                end
                S_ADD: begin
                    r_a          <= r_a >> 1;
                    r_b          <= r_b >> 1;
                    r_sum[r_cnt] <= w_sum_bit;
                    r_carry      <= w_carry_next;
                    // Counter saturates on the last bit so it never wraps.
                    if (r_cnt != LAST_BIT) r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign res_sum   = r_sum;
    assign res_carry = r_carry;
    assign res_id    = r_id;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Randomized self-checking bench for serial_add_arbiter at WIDTH 1, 8 and 16,
// checked against a word-level add and a round-robin grant model.
module tb_serial_add_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v0 [3];
    logic        v1 [3];
    logic        rr [3];
    logic [15:0] a0 [3];
    logic [15:0] b0 [3];
    logic [15:0] a1 [3];
    logic [15:0] b1 [3];

    logic r0_1, r1_1, rv_1, rc_1, rid_1;
    logic [0:0] rs_1;
    logic r0_8, r1_8, rv_8, rc_8, rid_8;
    logic [7:0] rs_8;
    logic r0_16, r1_16, rv_16, rc_16, rid_16;
    logic [15:0] rs_16;

    int errors = 0;
    int checks = 0;
    int wid [3] = '{1, 8, 16};
    logic m_last [3];

    serial_add_arbiter #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0[0]), .req0_ready(r0_1), .req0_a(a0[0][0:0]), .req0_b(b0[0][0:0]),
        .req1_valid(v1[0]), .req1_ready(r1_1), .req1_a(a1[0][0:0]), .req1_b(b1[0][0:0]),
        .res_valid(rv_1), .res_ready(rr[0]), .res_sum(rs_1), .res_carry(rc_1), .res_id(rid_1)
    );

    serial_add_arbiter #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst),
        .req0_valid(v0[1]), .req0_ready(r0_8), .req0_a(a0[1][7:0]), .req0_b(b0[1][7:0]),
        .req1_valid(v1[1]), .req1_ready(r1_8), .req1_a(a1[1][7:0]), .req1_b(b1[1][7:0]),
        .res_valid(rv_8), .res_ready(rr[1]), .res_sum(rs_8), .res_carry(rc_8), .res_id(rid_8)
    );

    serial_add_arbiter #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst),
        .req0_valid(v0[2]), .req0_ready(r0_16), .req0_a(a0[2]), .req0_b(b0[2]),
        .req1_valid(v1[2]), .req1_ready(r1_16), .req1_a(a1[2]), .req1_b(b1[2]),
        .res_valid(rv_16), .res_ready(rr[2]), .res_sum(rs_16), .res_carry(rc_16), .res_id(rid_16)
    );

    typedef struct packed {
        logic        rv;
        logic        rdy0;
        logic        rdy1;
        logic        rc;
        logic        rid;
        logic [15:0] rs;
    } obs_t;

    function automatic obs_t rd(input int k);
        obs_t o;
        o = '0;
        case (k)
            0: begin
                o.rv = rv_1; o.rdy0 = r0_1; o.rdy1 = r1_1; o.rc = rc_1; o.rid = rid_1;
                o.rs = {15'd0, rs_1};
            end
            1: begin
                o.rv = rv_8; o.rdy0 = r0_8; o.rdy1 = r1_8; o.rc = rc_8; o.rid = rid_8;
                o.rs = {8'd0, rs_8};
            end
            default: begin
                o.rv = rv_16; o.rdy0 = r0_16; o.rdy1 = r1_16; o.rc = rc_16; o.rid = rid_16;
                o.rs = rs_16;
            end
        endcase
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on instance k; bp = cycles of result backpressure.
    task automatic run_op(input int k, input logic va0, input logic va1,
                          input logic [15:0] xa0, input logic [15:0] xb0,
                          input logic [15:0] xa1, input logic [15:0] xb1, input int bp);
        int          w;
        int          n;
        logic        g;
        logic [16:0] t;
        logic [15:0] mask;
        logic [16:0] full;
        logic [15:0] exp_sum;
        logic        exp_c;
        obs_t        o;
        obs_t        hold;
        w    = wid[k];
        t    = (17'h1 << w) - 17'h1;
        mask = t[15:0];
        a0[k] = xa0 & mask; b0[k] = xb0 & mask;
        a1[k] = xa1 & mask; b1[k] = xb1 & mask;
        v0[k] = va0; v1[k] = va1;
        rr[k] = (bp == 0);
        if (va0 && va1) g = ~m_last[k];
        else            g = va0 ? 1'b0 : 1'b1;
        full    = g ? ({1'b0, a1[k]} + {1'b0, b1[k]}) : ({1'b0, a0[k]} + {1'b0, b0[k]});
        exp_sum = full[15:0] & mask;
        exp_c   = full[w];
        #1;
        o = rd(k);
        checks++;
        if (o.rdy0 !== (g == 1'b0) || o.rdy1 !== (g == 1'b1)) begin
            errors++;
            $display("FAIL grant w=%0d: ready0/1=%b%b expected grant %0d", w, o.rdy0, o.rdy1, g);
        end
        @(posedge clk);
        #1;
        v0[k] = 1'b0; v1[k] = 1'b0;
        m_last[k] = g;
        n = 0;
        o = rd(k);
        while (o.rv !== 1'b1 && n < 40) begin
            step();
            n++;
            o = rd(k);
        end
        checks++;
        if (n !== w) begin
            errors++;
            $display("FAIL latency w=%0d: res_valid after %0d cycles expected %0d", w, n, w);
        end
        checks++;
        if (o.rs !== exp_sum || o.rc !== exp_c || o.rid !== g) begin
            errors++;
            $display("FAIL result w=%0d: sum=%h carry=%b id=%b expected sum=%h carry=%b id=%b",
                     w, o.rs, o.rc, o.rid, exp_sum, exp_c, g);
        end
        if (bp > 0) begin
            hold = o;
            for (int i = 0; i < bp; i++) begin
                step();
                v0[k] = 1'b1; v1[k] = 1'b1;
                #1;
                o = rd(k);
                checks++;
                if (o !== hold) begin
                    errors++;
                    $display("FAIL backpressure w=%0d cycle %0d: obs=%h expected %h", w, i, o, hold);
                end
            end
            v0[k] = 1'b0; v1[k] = 1'b0;
            rr[k] = 1'b1;
        end
        step();
        o = rd(k);
        checks++;
        if (o.rv !== 1'b0) begin
            errors++;
            $display("FAIL release w=%0d: res_valid=%b expected 0", w, o.rv);
        end
        rr[k] = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) m_last[k] = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o;
        v0[1] = 1'b1; v1[1] = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (r0_8 !== 1'b0 || r1_8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready0/1=%b%b expected 00", r0_8, r1_8);
        end
        step();
        step();
        v0[1] = 1'b0; v1[1] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) m_last[k] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            o = rd(k);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset_state inst %0d: obs=%h expected 0", k, o);
            end
        end
    endtask

    task automatic test_single();
        run_op(1, 1'b1, 1'b0, 16'h3C, 16'h0F, 16'h00, 16'h00, 0);
    endtask

    task automatic test_overflow();
        run_op(1, 1'b0, 1'b1, 16'h00, 16'h00, 16'hFF, 16'h01, 0);
        run_op(1, 1'b0, 1'b1, 16'h00, 16'h00, 16'hFF, 16'hFF, 0);
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 4; i++)
            run_op(1, 1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0);
    endtask

    task automatic test_backpressure();
        run_op(1, 1'b1, 1'b0, 16'hA5, 16'h7E, 16'h00, 16'h00, 5);
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        a0[1] = 16'h55; b0[1] = 16'h66;
        v0[1] = 1'b1;
        step();
        v0[1] = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) m_last[k] = 1'b1;
        o = rd(1);
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: obs=%h expected 0", o);
        end
        run_op(1, 1'b0, 1'b1, 16'h00, 16'h00, 16'h12, 16'h34, 0);
        run_op(1, 1'b1, 1'b1, 16'h21, 16'h43, 16'h99, 16'h88, 0);
    endtask

    task automatic test_width1();
        run_op(0, 1'b1, 1'b0, 16'h1, 16'h1, 16'h0, 16'h0, 0);
        run_op(0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h1, 16'h0, 0);
        run_op(0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h1, 16'h1, 2);
    endtask

    task automatic test_sweep(input int k, input int count);
        logic [1:0] sel;
        for (int i = 0; i < count; i++) begin
            sel = 2'($urandom_range(1, 3));
            run_op(k, sel[0], sel[1], 16'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), (i % 97 == 0) ? 2 : 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v0[k] = 1'b0; v1[k] = 1'b0; rr[k] = 1'b0;
            a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
            m_last[k] = 1'b1;
        end
        step();
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_width1();
        test_sweep(1, 1000);
        test_sweep(2, 1000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Controller that shares one bit-serial full adder between two requesters. Each requester presents a pair of WIDTH-bit operands with a valid/ready handshake. A round-robin arbiter grants one requester, and the block streams the operands LSB-first through a single 1-bit adder stage for WIDTH cycles. It then returns the WIDTH-bit sum, the carry-out and the requester id on a valid/ready result port. It sits between word-level producers and the team's serial-arithmetic datapath.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range ≥ 1.

Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle when valid is also high.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  WIDTH  (a + b) mod 2^WIDTH.
- res_carry  out  1  bit WIDTH of a + b.
- res_id  out  1  requester that owns the result (0 or 1).

## Operation
- Adder stage uses only XOR/AND/OR/NOT:
  - sum bit = a_i ^ b_i ^ c.
  - c_next = (a_i & b_i) | (c & (a_i ^ b_i)).
- FSM states:
  - IDLE: arbitrates. If exactly one reqN_valid is high, that requester is granted. If both are high, the requester not granted last time is granted. reqN_ready = (state==IDLE) && grant==N, computed combinationally from the valids. The other ready is 0.
    - On handshake: latch a, b and id; clear the carry; clear the bit counter; update last_grant; go to ADD.
  - ADD: each cycle processes bit[cnt] of the latched operands and writes the sum bit into the result shift register; the carry register updates. After the cycle with cnt == WIDTH-1, the carry holds the carry-out; go to DONE.
  - DONE: res_valid = 1. res_sum, res_carry and res_id are stable until the handshake. On res_valid && res_ready, go to IDLE.
- Both reqN_ready are 0 in ADD and DONE; requests wait while the block is busy.
- Counter width is clog2(WIDTH) with a minimum of 1 bit. It never wraps during an operation.
- Reset values: state IDLE, res_valid 0, res_sum 0, res_carry 0, res_id 0, carry 0, counter 0, last_grant 1 (so requester 0 wins the first tie). Both readies are 0 during the reset cycle.
- Reset during ADD or DONE aborts the operation; the in-flight result is discarded and never presented.

## Timing
- Accept edge = end of cycle T, when valid && ready.
- ADD occupies cycles T+1 .. T+WIDTH.
- res_valid is first high in cycle T+WIDTH+1.
- If res_ready is high in that cycle, the block is back in IDLE at T+WIDTH+2 and can accept again in that cycle. Minimum period is WIDTH+2 cycles per operation.
- With res_ready held low, outputs hold indefinitely and no new request is accepted.
- Request arriving while busy: it is granted in the first IDLE cycle, round-robin applied at that moment.
- Requester dropping valid before grant: nothing is latched and there is no side effect.

## Test plan
- Single add, WIDTH=8: req0 A=8'h3C, B=8'h0F, res_ready=1 -> res_valid first high 9 cycles after accept; res_sum=8'h4B, res_carry=0, res_id=0.
- Overflow: req1 A=8'hFF, B=8'h01 -> res_sum=8'h00, res_carry=1, res_id=1. Also A=8'hFF, B=8'hFF -> 8'hFE, carry 1.
- Tie and round-robin: both valid continuously, out of reset -> grants in order 0,1,0,1. Each result id matches its grant and each sum is correct. Exactly one ready is high per accept.
- Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_sum, res_carry and res_id stay constant; both readies stay 0. Raising res_ready -> IDLE on the next cycle.
- Reset mid-op: assert rst for one cycle at ADD bit 3 -> next cycle res_valid=0, all outputs 0, state IDLE. The next request (req1 only) completes correctly. On a subsequent tie, req0 wins.
- Parameter corner: WIDTH=1, A=1, B=1 -> res_sum=0, res_carry=1, latency 2 cycles to res_valid. Also a random sweep of 1000 operations against a + b for WIDTH=8 and WIDTH=16.
